// File: rtl/nes_pkg.sv
// Shared PPU definitions: register offsets, OAM sizing and the OAM DMA state type.
package nes_pkg;

  localparam logic [2:0] PPU_OAMADDR = 3'd3;
  localparam logic [2:0] PPU_OAMDATA = 3'd4;

  localparam int unsigned OAM_DEPTH_DEFAULT = 256;
  localparam logic [7:0]  ATTR_MASK_DEFAULT = 8'hE3;

  typedef enum logic [1:0] {OAM_IDLE, OAM_ACTIVE, OAM_DONE} oam_dma_state_t;

  // Attribute bytes (index % 4 == 2) have unimplemented bits that must read back as zero.
  function automatic logic [7:0] oam_wr_mask(input logic [1:0] idx_lo, input logic [7:0] data,
                                             input logic [7:0] mask);
    return (idx_lo == 2'd2) ? (data & mask) : data;
  endfunction

endpackage

// File: rtl/oam_ram.sv
// OAM storage: one write port, two registered read ports, read-before-write on collision.
module oam_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [Aw-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_rd_a_en,
  input  logic [Aw-1:0] i_rd_a_addr,
  output logic [7:0]    o_rd_a_data,
  input  logic          i_rd_b_en,
  input  logic [Aw-1:0] i_rd_b_addr,
  output logic [7:0]    o_rd_b_data
);

  logic [7:0] r_mem [Depth];
  logic [7:0] r_rd_a;
  logic [7:0] r_rd_b;

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_a <= 8'h00;
      r_rd_b <= 8'h00;
    end else if (i_en) begin
      if (i_rd_a_en) r_rd_a <= r_mem[i_rd_a_addr];
      if (i_rd_b_en) r_rd_b <= r_mem[i_rd_b_addr];
    end
  end

  assign o_rd_a_data = r_rd_a;
  assign o_rd_b_data = r_rd_b;

endmodule

// File: rtl/ppu_oam_port.sv
// PPU-side OAM responder: $2003/$2004 CPU access, $4014 DMA sink and renderer read port.
// Define OAM_DMA_CHECK_EN to enable DMA sequence checking on dma_error.
module ppu_oam_port
  import nes_pkg::*;
#(
  parameter int unsigned OAM_DEPTH = OAM_DEPTH_DEFAULT,
  parameter logic [7:0]  ATTR_MASK = ATTR_MASK_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       ENABLE,
  input  logic [2:0] CPU_ADDR,
  input  logic [7:0] CPU_DATA_IN,
  input  logic       CPU_wren,
  input  logic       CPU_rden,
  output logic [7:0] CPU_DATA_OUT,
  input  logic       DMA_write,
  input  logic [7:0] DMA_address,
  input  logic [7:0] DMA_data,
  input  logic       render_rden,
  input  logic [7:0] render_addr,
  output logic [7:0] render_data,
  output logic       dma_busy,
  output logic       dma_done,
  output logic       dma_error,
  output logic [7:0] oam_addr_dbg
);

  localparam int unsigned Aw = $clog2(OAM_DEPTH);

  oam_dma_state_t r_state, w_state_d;
  logic [7:0]     r_oam_addr, w_oam_addr_d;
  logic           w_we;
  logic [7:0]     w_waddr;
  logic [7:0]     w_wdata;
  logic           w_cpu_rd;
  logic           w_cpu_wr_addr;
  logic           w_cpu_wr_data;

`ifdef OAM_DMA_CHECK_EN
  logic [7:0] r_cnt, w_cnt_d;
  logic       r_err, w_err_d;
`endif

  assign w_cpu_wr_addr = CPU_wren && (CPU_ADDR == PPU_OAMADDR);
  assign w_cpu_wr_data = CPU_wren && (CPU_ADDR == PPU_OAMDATA);

  always_comb begin
    w_state_d    = r_state;
    w_oam_addr_d = r_oam_addr;
    w_we         = 1'b0;
    w_waddr      = r_oam_addr + DMA_address;
    w_wdata      = DMA_data;
    w_cpu_rd     = 1'b0;
`ifdef OAM_DMA_CHECK_EN
    w_cnt_d      = r_cnt;
    w_err_d      = r_err;
`endif
    unique case (r_state)
      OAM_IDLE: begin
        w_cpu_rd = CPU_rden && (CPU_ADDR == PPU_OAMDATA);
        if (DMA_write) begin
          // DMA owns the cycle; a coincident CPU write is dropped.
`ifdef OAM_DMA_CHECK_EN
          if (DMA_address == 8'h00) begin
            w_we      = 1'b1;
            w_cnt_d   = 8'd1;
            w_state_d = OAM_ACTIVE;
          end else begin
            w_err_d = 1'b1;
          end
`else
          w_we      = 1'b1;
          w_state_d = (DMA_address == 8'hFF) ? OAM_DONE : OAM_ACTIVE;
`endif
        end else if (w_cpu_wr_addr) begin
          w_oam_addr_d = CPU_DATA_IN;
`ifdef OAM_DMA_CHECK_EN
          w_err_d      = 1'b0;
`endif
        end else if (w_cpu_wr_data) begin
          w_we         = 1'b1;
          w_waddr      = r_oam_addr;
          w_wdata      = CPU_DATA_IN;
          w_oam_addr_d = r_oam_addr + 8'd1;
        end
      end
      OAM_ACTIVE: begin
        if (DMA_write) begin
          w_we = 1'b1;
`ifdef OAM_DMA_CHECK_EN
          if (DMA_address != r_cnt) w_err_d = 1'b1;
          w_cnt_d = r_cnt + 8'd1;
`endif
          if (DMA_address == 8'hFF) w_state_d = OAM_DONE;
        end
      end
      OAM_DONE: w_state_d = OAM_IDLE;
      default:  w_state_d = OAM_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= OAM_IDLE;
      r_oam_addr <= 8'h00;
    end else if (ENABLE) begin
      r_state    <= w_state_d;
      r_oam_addr <= w_oam_addr_d;
    end
  end

`ifdef OAM_DMA_CHECK_EN
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_cnt <= 8'h00;
      r_err <= 1'b0;
    end else if (ENABLE) begin
      r_cnt <= w_cnt_d;
      r_err <= w_err_d;
    end
  end
  assign dma_error = r_err;
`else
  assign dma_error = 1'b0;
`endif

  oam_ram #(
    .Depth (OAM_DEPTH),
    .Aw    (Aw)
  ) u_oam_ram (
    .i_clk       (CLK),
    .i_rst_n     (RESET_n),
    .i_en        (ENABLE),
    .i_we        (w_we),
    .i_waddr     (w_waddr[Aw-1:0]),
    .i_wdata     (oam_wr_mask(w_waddr[1:0], w_wdata, ATTR_MASK)),
    .i_rd_a_en   (w_cpu_rd),
    .i_rd_a_addr (r_oam_addr[Aw-1:0]),
    .o_rd_a_data (CPU_DATA_OUT),
    .i_rd_b_en   (render_rden),
    .i_rd_b_addr (render_addr[Aw-1:0]),
    .o_rd_b_data (render_data)
  );

  assign dma_busy     = (r_state == OAM_ACTIVE);
  assign dma_done     = (r_state == OAM_DONE);
  assign oam_addr_dbg = r_oam_addr;

endmodule

// File: tb/tb_ppu_oam_port.sv
// Scoreboard bench for ppu_oam_port: read responses are queued at issue and checked by a monitor.
module tb_ppu_oam_port;

`ifdef OAM_DMA_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] cpu_addr = 3'd0;
  logic [7:0] cpu_din = 8'h00;
  logic       cpu_wren = 1'b0;
  logic       cpu_rden = 1'b0;
  logic [7:0] cpu_dout;
  logic       dma_wr = 1'b0;
  logic [7:0] dma_addr = 8'h00;
  logic [7:0] dma_din = 8'h00;
  logic       rnd_rden = 1'b0;
  logic [7:0] rnd_addr = 8'h00;
  logic [7:0] rnd_data;
  logic       busy, done, err;
  logic [7:0] oam_dbg;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [7:0] mem_m [256];
  logic [7:0] m_oam = 8'h00;
  logic [7:0] cpu_q [$];
  logic [7:0] rnd_q [$];
  logic       cpu_v = 1'b0;
  logic       rnd_v = 1'b0;

  ppu_oam_port dut (
    .CLK          (clk),
    .RESET_n      (rst_n),
    .ENABLE       (enable),
    .CPU_ADDR     (cpu_addr),
    .CPU_DATA_IN  (cpu_din),
    .CPU_wren     (cpu_wren),
    .CPU_rden     (cpu_rden),
    .CPU_DATA_OUT (cpu_dout),
    .DMA_write    (dma_wr),
    .DMA_address  (dma_addr),
    .DMA_data     (dma_din),
    .render_rden  (rnd_rden),
    .render_addr  (rnd_addr),
    .render_data  (rnd_data),
    .dma_busy     (busy),
    .dma_done     (done),
    .dma_error    (err),
    .oam_addr_dbg (oam_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] msk(input logic [7:0] idx, input logic [7:0] d);
    return (idx[1:0] == 2'd2) ? (d & 8'hE3) : d;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cpu_v <= cpu_rden && enable && rst_n;
    rnd_v <= rnd_rden && enable && rst_n;
  end

  always @(negedge clk) begin
    if (cpu_v) begin
      if (cpu_q.size() == 0) check("cpu_rd_unexpected", cpu_dout, 8'hxx);
      else check("cpu_rd", cpu_dout, cpu_q.pop_front());
    end
    if (rnd_v) begin
      if (rnd_q.size() == 0) check("render_unexpected", rnd_data, 8'hxx);
      else check("render_rd", rnd_data, rnd_q.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_wren = 1'b1;
    tick();
    cpu_wren = 1'b0;
    if (a == 3'd3) m_oam = d;
    else if (a == 3'd4) begin
      mem_m[m_oam] = msk(m_oam, d);
      m_oam = m_oam + 8'd1;
    end
  endtask

  task automatic cpu_rd();
    cpu_addr = 3'd4; cpu_rden = 1'b1;
    cpu_q.push_back(mem_m[m_oam]);
    tick();
    cpu_rden = 1'b0;
  endtask

  task automatic rd_x(input logic [7:0] a, input logic [7:0] exp);
    rnd_addr = a; rnd_rden = 1'b1;
    rnd_q.push_back(exp);
    tick();
    rnd_rden = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_x(a, mem_m[a]);
  endtask

  task automatic dma(input logic [7:0] idx, input logic [7:0] d);
    logic [7:0] p;
    dma_wr = 1'b1; dma_addr = idx; dma_din = d;
    p = m_oam + idx;
    mem_m[p] = msk(p, d);
    tick();
    dma_wr = 1'b0;
  endtask

  task automatic check_done_pulse(input string name);
    @(negedge clk);
    check({name, "_done"}, {7'd0, done}, 8'd1);
    check({name, "_busy_in_done"}, {7'd0, busy}, 8'd0);
    @(negedge clk);
    check({name, "_done_clear"}, {7'd0, done}, 8'd0);
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    repeat (3) tick();
    check("rst_cpu_dout", cpu_dout, 8'h00);
    check("rst_render", rnd_data, 8'h00);
    check("rst_flags", {5'd0, busy, done, err}, 8'h00);
    check("rst_oam_addr", oam_dbg, 8'h00);
    rst_n = 1'b1;
    tick();

    // CPU path with attribute masking on byte 18
    cpu_wr(3'd3, 8'h10);
    cpu_wr(3'd4, 8'hAA);
    cpu_wr(3'd4, 8'hBB);
    cpu_wr(3'd4, 8'hCC);
    check("t1_oam_addr", oam_dbg, 8'h13);
    rd_x(8'd16, 8'hAA);
    rd_x(8'd17, 8'hBB);
    rd_x(8'd18, 8'hC0);
    cpu_wr(3'd3, 8'h10);
    cpu_rd();
    cpu_rd();
    check("t1_rd_no_incr", oam_dbg, 8'h10);
    cpu_wr(3'd2, 8'h99);
    check("t1_other_offset", oam_dbg, 8'h10);

    // ENABLE low freezes state
    enable = 1'b0;
    cpu_addr = 3'd3; cpu_din = 8'h99; cpu_wren = 1'b1;
    tick();
    cpu_wren = 1'b0;
    enable = 1'b1;
    check("en_hold", oam_dbg, 8'h10);

    // Full DMA from oam_addr 4 with stalls
    cpu_wr(3'd3, 8'h04);
    done_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 50 || i == 120 || i == 200) tick();
      v = i[7:0];
      dma(v, v);
      if (i == 10) check("t2_busy", {7'd0, busy}, 8'd1);
    end
    check_done_pulse("t2");
    check("t2_done_once", done_cnt[7:0], 8'd1);
    check("t2_oam_addr", oam_dbg, 8'h04);
    check("t2_err", {7'd0, err}, 8'd0);
    rd_x(8'h06, 8'h02);
    rd_x(8'h02, 8'hE2);
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      rd(v);
    end

    // Skipped index 7
    cpu_wr(3'd3, 8'h00);
    for (int i = 0; i < 256; i++) begin
      if (i != 7) begin
        v = i[7:0];
        dma(v, v ^ 8'h3C);
        if (i == 6) begin
          @(negedge clk);
          check("t3_err_before", {7'd0, err}, 8'd0);
        end
        if (i == 8) begin
          @(negedge clk);
          check("t3_err_after", {7'd0, err}, {7'd0, Chk});
        end
      end
    end
    check_done_pulse("t3");
    check("t3_err_sticky", {7'd0, err}, {7'd0, Chk});
    cpu_wr(3'd3, 8'h00);
    check("t3_err_cleared", {7'd0, err}, 8'd0);

    // CPU write ignored while active; render read-before-write
    for (int i = 0; i < 32; i++) begin
      v = i[7:0];
      dma(v, 8'hC3 ^ v);
    end
    dma_wr = 1'b1; dma_addr = 8'h20; dma_din = 8'h77;
    rnd_rden = 1'b1; rnd_addr = 8'h20;
    rnd_q.push_back(mem_m[8'h20]);
    tick();
    dma_wr = 1'b0; rnd_rden = 1'b0;
    mem_m[8'h20] = 8'h77;
    rd_x(8'h20, 8'h77);
    cpu_addr = 3'd3; cpu_din = 8'h55; cpu_wren = 1'b1;
    tick();
    cpu_wren = 1'b0;
    for (int i = 33; i < 256; i++) begin
      v = i[7:0];
      dma(v, 8'hC3 ^ v);
    end
    check_done_pulse("t4");
    check("t4_oam_addr", oam_dbg, 8'h00);
    check("t4_err", {7'd0, err}, 8'd0);

    // Reset mid-transfer
    for (int i = 0; i <= 100; i++) begin
      v = i[7:0];
      dma(v, ~v);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy_rst", {7'd0, busy}, 8'd0);
    check("t6_done_rst", {7'd0, done}, 8'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rd(8'd50);
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      dma(v, v ^ 8'h5A);
    end
    check_done_pulse("t6");
    check("t6_err", {7'd0, err}, 8'd0);
    rd(8'd0);
    rd(8'd2);
    rd(8'd100);
    rd(8'd255);
    repeat (3) tick();

    check("cpu_q_drained", cpu_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    check("rnd_q_drained", rnd_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
